// File: rtl/pwm_pkg.sv
// Shared constants and bus helpers for the multi-channel PWM divider.
package pwm_pkg;

  localparam int WIDTH_DEF          = 8;
  localparam int DEFAULT_PERIOD_DEF = 10;

  // Start bit of channel i inside a packed per-channel bus.
  function automatic int duty_slice(input int i, input int width);
    return i * width;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadowed duty value, active duty value and the registered output.
module pwm_channel #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ch_en,
  input  logic             load,
  input  logic             apply,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out
);

  logic [WIDTH-1:0] duty_sh;
  logic [WIDTH-1:0] duty_act;

  // The active duty only changes on the shared apply strobe, so a wave in flight is never cut short.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm_out  <= IDLE_LVL;
    end else begin
      if (load) begin
        duty_sh <= duty_in;
      end
      if (apply) begin
        duty_act <= duty_sh;
      end
      pwm_out <= (enable && ch_en) ? (cnt < duty_act) : IDLE_LVL;
    end
  end

endmodule

// File: rtl/pwm_divider_multi.sv
// Multi-channel PWM divider: one shared period counter feeding per-channel comparators,
// with period/duty updates deferred to the next period boundary.
module pwm_divider_multi
  import pwm_pkg::*;
#(
  parameter int                  WIDTH          = WIDTH_DEF,
  parameter int                  CHANNELS       = 4,
  parameter int                  DEFAULT_PERIOD = DEFAULT_PERIOD_DEF,
  parameter logic [CHANNELS-1:0] IDLE_POL       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_tick,
  output logic                      update_pending
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] per_act;
  logic [WIDTH-1:0] per_sh;
  logic             wrap;
  logic             apply;

  // Periods of 0 or 1 wrap every cycle so the counter stays parked at 0.
  assign wrap  = (per_act <= WIDTH'(1)) || (cnt == per_act - WIDTH'(1));
  // A load in the same cycle defers everything pending to the following boundary.
  assign apply = update_pending && !load && (!enable || wrap);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      per_act        <= WIDTH'(DEFAULT_PERIOD);
      per_sh         <= WIDTH'(DEFAULT_PERIOD);
      update_pending <= 1'b0;
      period_tick    <= 1'b0;
    end else begin
      if (enable) begin
        cnt         <= wrap ? '0 : cnt + WIDTH'(1);
        period_tick <= wrap;
      end else begin
        cnt         <= '0;
        period_tick <= 1'b0;
      end
      if (load) begin
        per_sh         <= period_in;
        update_pending <= 1'b1;
      end else if (apply) begin
        per_act        <= per_sh;
        update_pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH   (WIDTH),
      .IDLE_LVL(IDLE_POL[i])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .ch_en  (ch_en[i]),
      .load   (load),
      .apply  (apply),
      .cnt    (cnt),
      .duty_in(duty_in[duty_slice(i, WIDTH) +: WIDTH]),
      .pwm_out(pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_divider_multi.sv
// Scoreboard bench for pwm_divider_multi: a per-cycle behavioural model predicts outputs,
// a monitor compares them against the DUT one edge later.
module tb_pwm_divider_multi;

  localparam int          W    = 8;
  localparam int          CH   = 4;
  localparam logic [3:0]  IDLE = 4'b0010;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [CH-1:0] ch_en = '1;
  logic [W-1:0]  period_in = '0;
  logic [CH*W-1:0] duty_in = '0;
  logic          load = 1'b0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic          update_pending;

  typedef struct {
    logic [3:0] pwm;
    logic       tick;
    logic       pend;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   cycle_no  = 0;

  // Reference state, kept as plain integers.
  int m_pos, m_period, m_period_sh, m_pend;
  int m_duty[CH];
  int m_duty_sh[CH];

  logic       cur_en = 1'b0;
  logic [3:0] cur_ce = 4'b1111;

  always #5 clk = ~clk;

  pwm_divider_multi #(
    .WIDTH         (W),
    .CHANNELS      (CH),
    .DEFAULT_PERIOD(10),
    .IDLE_POL      (IDLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .ch_en         (ch_en),
    .period_in     (period_in),
    .duty_in       (duty_in),
    .load          (load),
    .pwm_out       (pwm_out),
    .period_tick   (period_tick),
    .update_pending(update_pending)
  );

  task automatic modelStep(input logic r, input logic en, input logic [3:0] ce,
                           input logic ld, input int per, input logic [31:0] dty);
    exp_t e;
    bit   at_end;
    e.cyc = cycle_no;
    if (r) begin
      e.pwm  = IDLE;
      e.tick = 1'b0;
      e.pend = 1'b0;
      m_pos = 0; m_period = 10; m_period_sh = 10; m_pend = 0;
      for (int i = 0; i < CH; i++) begin
        m_duty[i] = 0;
        m_duty_sh[i] = 0;
      end
    end else begin
      at_end = (m_period <= 1) || (m_pos == m_period - 1);
      for (int i = 0; i < CH; i++)
        e.pwm[i] = (en && ce[i]) ? (m_pos < m_duty[i]) : IDLE[i];
      e.tick = en && at_end;
      if (ld) begin
        m_period_sh = per;
        for (int i = 0; i < CH; i++) m_duty_sh[i] = int'(dty[i*W +: W]);
        m_pend = 1;
      end else if (m_pend == 1 && (!en || at_end)) begin
        m_period = m_period_sh;
        for (int i = 0; i < CH; i++) m_duty[i] = m_duty_sh[i];
        m_pend = 0;
      end
      m_pos = (en && !at_end) ? m_pos + 1 : 0;
      e.pend = (m_pend == 1);
    end
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic [3:0] ce,
                               input logic ld, input logic [7:0] per, input logic [31:0] dty);
    @(negedge clk);
    reset     = r;
    enable    = en;
    ch_en     = ce;
    load      = ld;
    period_in = per;
    duty_in   = dty;
    cycle_no++;
    modelStep(r, en, ce, ld, int'(per), dty);
  endtask

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, cur_en, cur_ce, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic loadValues(input logic [7:0] per, input logic [31:0] dty);
    applyStimulus(1'b0, cur_en, cur_ce, 1'b1, per, dty);
  endtask

  task automatic waitPos(input int target);
    for (int k = 0; k < 40 && m_pos != target; k++) runCycles(1);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pwm_out",        e.cyc, 32'(pwm_out),        32'(e.pwm));
        checkOutput("period_tick",    e.cyc, 32'(period_tick),    32'(e.tick));
        checkOutput("update_pending", e.cyc, 32'(update_pending), 32'(e.pend));
      end
    end
  end

  initial begin
    int drain;
    applyStimulus(1'b1, 1'b0, 4'b1111, 1'b0, 8'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 4'b1111, 1'b0, 8'd0, 32'd0);

    // Basic waveform plus duty extremes: ch0=5, ch1=3, ch2=0, ch3=10 over period 10.
    cur_en = 1'b0;
    loadValues(8'd10, {8'd10, 8'd0, 8'd3, 8'd5});
    runCycles(1);
    cur_en = 1'b1;
    runCycles(32);

    // Mid-period load.
    waitPos(4);
    loadValues(8'd6, {8'd10, 8'd0, 8'd3, 8'd2});
    runCycles(20);

    // Load exactly on the wrap cycle: deferred by a full period.
    waitPos(5);
    loadValues(8'd10, {8'd10, 8'd0, 8'd3, 8'd5});
    runCycles(3);
    waitPos(9);
    loadValues(8'd10, {8'd9, 8'd1, 8'd7, 8'd4});
    runCycles(25);

    // Periods 1 and 0.
    waitPos(9);
    loadValues(8'd1, {8'd0, 8'd1, 8'd5, 8'd0});
    runCycles(6);
    loadValues(8'd0, {8'd1, 8'd0, 8'd0, 8'd3});
    runCycles(6);

    // Reset in the middle of a period with channel 1 disabled.
    loadValues(8'd10, {8'd10, 8'd0, 8'd3, 8'd5});
    runCycles(12);
    cur_ce = 4'b1101;
    waitPos(7);
    applyStimulus(1'b1, cur_en, cur_ce, 1'b0, 8'd0, 32'd0);
    runCycles(4);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      logic        r, ld;
      logic [7:0]  per;
      logic [31:0] dty;
      r   = ($urandom_range(0, 99) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      per = 8'($urandom_range(0, 16));
      for (int i = 0; i < CH; i++) dty[i*W +: W] = 8'($urandom_range(0, 18));
      if ($urandom_range(0, 19) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 14) == 0) cur_ce = 4'($urandom_range(0, 15));
      applyStimulus(r, cur_en, cur_ce, ld, per, dty);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
